// File: rtl/ber_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ber_test_ctrl
// Description : Bit-error-rate test controller. Discards SYNC_WORDS valid
//               words after start, then counts words, bits and bit errors
//               (popcount of err_vec) over a num_words window. Optional
//               early stop on an error threshold is built when the macro
//               BER_ERR_LIMIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ber_test_ctrl #(
    parameter int WORD_W     = 8,
    parameter int CNT_W      = 32,
    parameter int SYNC_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_words,
    input  logic [CNT_W-1:0] err_limit,
    input  logic             word_valid,
    input  logic [WORD_W-1:0] err_vec,
    output logic             cmp_en,
    output logic             busy,
    output logic             done,
    output logic             limit_hit,
    output logic             overflow,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int c_POP_W  = $clog2(WORD_W + 1);
    localparam int c_SYNC_W = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SYNC = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // With no discard window the test goes straight into counting.
    localparam logic [1:0]          c_FIRST_STATE = (SYNC_WORDS == 0) ? c_RUN : c_SYNC;
    localparam logic [CNT_W-1:0]    c_WORD_BITS   = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0]    c_CNT_MAX     = '1;
    localparam logic [c_SYNC_W-1:0] c_SYNC_LAST   = c_SYNC_W'((SYNC_WORDS > 0) ? SYNC_WORDS - 1 : 0);

    logic [1:0]          r_state;
    logic [c_SYNC_W-1:0] r_sync_cnt;
    logic [CNT_W-1:0]    r_num_words;
    logic [CNT_W-1:0]    r_word_count;
    logic [CNT_W-1:0]    r_bit_count;
    logic [CNT_W-1:0]    r_err_count;
    logic                r_done;
    logic                r_limit_hit;
    logic                r_overflow;

    logic [c_POP_W-1:0]  w_popcnt;
    logic [CNT_W:0]      w_err_sum;
    logic                w_err_sat;
    logic [CNT_W-1:0]    w_err_next;
    logic [CNT_W-1:0]    w_word_next;
    logic                w_last_word;
    logic                w_limit;

`ifdef BER_ERR_LIMIT_EN
    logic [CNT_W-1:0]    r_err_limit;

    // Early stop once the post-update error total reaches a non-zero limit.
    assign w_limit = (r_err_limit != '0) && (w_err_next >= r_err_limit);

    // Threshold is captured on an accepted start so it is stable for the test.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_limit <= '0;
        end else if ((r_state == c_IDLE || r_state == c_DONE) && start) begin
            r_err_limit <= err_limit;
        end
    end
`else
    logic w_unused_err_limit;

    // Without early stop the threshold input has no effect.
    assign w_unused_err_limit = ^err_limit;
    assign w_limit            = 1'b0;
`endif

    // Number of flagged bit errors in the current comparison word.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WORD_W; i++) begin
            w_popcnt = w_popcnt + c_POP_W'(err_vec[i]);
        end
    end

    // Saturating error accumulation; the carry-out marks a saturating add.
    assign w_err_sum   = {1'b0, r_err_count} + (CNT_W + 1)'(w_popcnt);
    assign w_err_sat   = w_err_sum[CNT_W];
    assign w_err_next  = w_err_sat ? c_CNT_MAX : w_err_sum[CNT_W-1:0];
    assign w_word_next = r_word_count + CNT_W'(1);
    assign w_last_word = (w_word_next == r_num_words);

    // Test sequencing FSM with all counters and status flags registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_sync_cnt   <= '0;
            r_num_words  <= '0;
            r_word_count <= '0;
            r_bit_count  <= '0;
            r_err_count  <= '0;
            r_done       <= 1'b0;
            r_limit_hit  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    // start wins over a simultaneous abort here.
                    if (start) begin
                        r_sync_cnt   <= '0;
                        r_num_words  <= num_words;
                        r_word_count <= '0;
                        r_bit_count  <= '0;
                        r_err_count  <= '0;
                        r_limit_hit  <= 1'b0;
                        r_overflow   <= 1'b0;
                        if (num_words == '0) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_FIRST_STATE;
                            r_done  <= 1'b0;
                        end
                    end
                end

                c_SYNC: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (word_valid) begin
                        if (r_sync_cnt == c_SYNC_LAST) begin
                            r_state <= c_RUN;
                        end else begin
                            r_sync_cnt <= r_sync_cnt + c_SYNC_W'(1);
                        end
                    end
                end

                c_RUN: begin
                    // Abort also discards a word arriving in the same cycle.
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (word_valid) begin
                        r_word_count <= w_word_next;
                        r_bit_count  <= r_bit_count + c_WORD_BITS;
                        r_err_count  <= w_err_next;
                        if (w_err_sat) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_limit) begin
                            r_limit_hit <= 1'b1;
                        end
                        if (w_last_word || w_limit) begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state == c_SYNC) || (r_state == c_RUN);
    assign cmp_en     = busy;
    assign done       = r_done;
    assign limit_hit  = r_limit_hit;
    assign overflow   = r_overflow;
    assign word_count = r_word_count;
    assign bit_count  = r_bit_count;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: doc/ber_test_ctrl.md
BER_TEST_CTRL -- requirements
Module: ber_test_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, width of comparator error vector in bits.
REQ-002 SHALL have parameter CNT_W, default 32, width of word, bit and error counters.
REQ-003 SHALL have parameter SYNC_WORDS, default 4, valid words discarded before counting starts (0 = no discard).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1, begin a test (level sampled each clk).
REQ-007 SHALL have port abort, input, 1, terminate a running test.
REQ-008 SHALL have port num_words, input, CNT_W, words to count in the measurement window; latched on accepted start.
REQ-009 SHALL have port err_limit, input, CNT_W, early-stop error threshold; latched on accepted start (see Configuration).
REQ-010 SHALL have port word_valid, input, 1, err_vec carries a fresh comparison this cycle.
REQ-011 SHALL have port err_vec, input, WORD_W, per-bit mismatch flags from the comparator (1 = error).
REQ-012 SHALL have port cmp_en, output, 1, enables the comparator/pattern path.
REQ-013 SHALL have ports busy, done, limit_hit, overflow, output, 1 each: test running; test complete; error limit reached; err_count saturated.
REQ-014 SHALL have ports word_count, bit_count, err_count, output, CNT_W each: counted words, counted bits, counted bit errors.

Function
REQ-015 SHALL implement states IDLE, SYNC, RUN, DONE; busy = (SYNC or RUN); cmp_en = busy.
REQ-016 IDLE or DONE with start=1 SHALL clear all counters, done, limit_hit and overflow, latch num_words/err_limit, and enter SYNC (RUN if SYNC_WORDS=0) next cycle.
REQ-017 Accepted start with num_words=0 SHALL go directly to DONE next cycle, counters 0.
REQ-018 start while busy SHALL be ignored.
REQ-019 SYNC SHALL count word_valid cycles, not touching outputs counters, and enter RUN on the cycle after the SYNC_WORDS-th valid word.
REQ-020 RUN, per word_valid: word_count += 1, bit_count += WORD_W, err_count += popcount(err_vec); visible cycle after word_valid.
REQ-021 err_count SHALL saturate at all-ones; overflow SHALL set on the first saturating add and stay set until next accepted start.
REQ-022 The valid word making word_count equal the latched num_words SHALL be counted and cause DONE next cycle; later word_valid ignored.
REQ-023 DONE SHALL hold done=1 and all counters until next accepted start.
REQ-024 abort=1 while busy SHALL enter IDLE next cycle, counters hold, done stays 0; abort in IDLE/DONE SHALL be ignored.
REQ-025 abort and final valid word in same cycle: abort wins; word not counted, next state IDLE.
REQ-026 start and abort together in IDLE/DONE: start accepted.

Reset
REQ-027 rst_n=0 at a clk edge SHALL force IDLE and zero every output and internal register, including mid-test.
REQ-028 Reset SHALL override start and abort.

Configuration
REQ-029 Macro BER_ERR_LIMIT_EN SHALL control early stop.
REQ-030 With BER_ERR_LIMIT_EN defined: in RUN, when the updated err_count >= latched err_limit (err_limit != 0), limit_hit SHALL assert and state SHALL enter DONE next cycle; limit_hit holds until next accepted start.
REQ-031 Without it: err_limit ignored, limit_hit constant 0, window ends only by num_words or abort.

Verification
REQ-032 start, num_words=10, SYNC_WORDS=4, 14 valid words err_vec=0 -> DONE, word_count=10, bit_count=80, err_count=0.
REQ-033 num_words=3, RUN words err_vec=8'h01, 8'hFF, 8'h81 -> err_count=11, bit_count=24, done=1.
REQ-034 num_words=100, abort after 5 RUN words -> IDLE, word_count=5, done=0; start again -> counters cleared.
REQ-035 BER_ERR_LIMIT_EN, err_limit=4, num_words=50, each word err_vec=8'h03 -> limit_hit and DONE after 2nd word, err_count=4, word_count=2.
REQ-036 CNT_W=4, num_words=3, err_vec=8'hFF each -> err_count=15, overflow=1; rst_n=0 in RUN -> all outputs 0 next cycle.
